// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line/status constants.
// The receiver imports the same package, so both sides of the link agree on
// the acknowledge polarity, the idle line level and the parity width.
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE     = 3'd0,
      TX_START    = 3'd1,
      TX_DATA     = 3'd2,
      TX_PARITY   = 3'd3,
      TX_STOP     = 3'd4,
      TX_ACK_WAIT = 3'd5
   } tx_state_t;

   localparam logic PCKT_OK       = 1'b0;
   localparam logic PCKT_NOT_OK   = 1'b1;
   localparam int   PARITY_LENGTH = 1;
   localparam logic IDLE_LEVEL    = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer. Counts 0..BIT_CYC-1 while enabled and raises tick on the
// last count. 'clear' restarts the period so a new bit always gets a full
// BIT_CYC cycles regardless of where the counter was.
module uart_baud_gen #(
   parameter int CLKRATE = 50_000_000,
   parameter int BAUD    = 115200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int BIT_CYC = CLKRATE / BAUD;
   localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

   logic [CW-1:0] cnt;

   // Bit-period counter: held at zero when cleared or disabled, wraps on the last count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || !en) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WORD_LENGTH data bits LSB-first, even parity,
// stop bit, then one bit period listening for a NOT_OK from the receiver.
// A NOT_OK in that window causes the same frame to be resent, up to MAX_RETRY
// times. The serial line is registered from the current state, so it trails
// the state register by one cycle.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKRATE     = 50_000_000,
   parameter int BAUD        = 115200,
   parameter int WORD_LENGTH = 8,
   parameter int MAX_RETRY   = 2
) (
   input  logic                   t_clk,
   input  logic                   t_rst_n,
   input  logic [WORD_LENGTH-1:0] tx_data,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   input  logic                   err_ack,
   output logic                   UART_Tx_OUT,
   output logic                   tx_busy,
   output logic                   tx_done,
   output logic                   tx_fail
);

   localparam int FW = WORD_LENGTH + PARITY_LENGTH;
   localparam int IW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(WORD_LENGTH - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   tx_state_t         state, state_nx;
   logic [FW-1:0]     frame, frame_nx;
   logic [IW-1:0]     bit_idx, bit_idx_nx;
   logic [RW-1:0]     retry, retry_nx;
   logic              nack, nack_nx, nack_now;
   logic              ack_meta, ack_sync;
   logic              line, line_nx;
   logic              ready, busy, done, fail;
   logic              done_nx, fail_nx;
   logic              tick;

   uart_baud_gen #(
      .CLKRATE (CLKRATE),
      .BAUD    (BAUD)
   ) u_baud (
      .clk   (t_clk),
      .rst_n (t_rst_n),
      .clear (state_nx != state),
      .en    (state != TX_IDLE),
      .tick  (tick)
   );

   // Two-stage synchroniser for the receiver's asynchronous acknowledge.
   always_ff @(posedge t_clk or negedge t_rst_n) begin
      if (!t_rst_n) begin
         ack_meta <= 1'b0;
         ack_sync <= 1'b0;
      end else begin
         ack_meta <= err_ack;
         ack_sync <= ack_meta;
      end
   end

   // Next-state, frame bookkeeping and next output values.
   always_comb begin
      state_nx   = state;
      frame_nx   = frame;
      bit_idx_nx = bit_idx;
      retry_nx   = retry;
      nack_nx    = 1'b0;
      done_nx    = 1'b0;
      fail_nx    = 1'b0;
      line_nx    = IDLE_LEVEL;
      nack_now   = nack || (ack_sync == PCKT_NOT_OK);
      case (state)
         TX_IDLE: begin
            line_nx = IDLE_LEVEL;
            if (tx_valid) begin
               state_nx   = TX_START;
               frame_nx   = {^tx_data, tx_data};
               retry_nx   = '0;
               bit_idx_nx = '0;
            end else begin
               state_nx = TX_IDLE;
            end
         end
         TX_START: begin
            line_nx    = 1'b0;
            bit_idx_nx = '0;
            if (tick) begin
               state_nx = TX_DATA;
            end else begin
               state_nx = TX_START;
            end
         end
         TX_DATA: begin
            line_nx = frame[bit_idx];
            if (tick && (bit_idx == LAST_IDX)) begin
               state_nx = TX_PARITY;
            end else if (tick) begin
               bit_idx_nx = bit_idx + IW'(1);
            end else begin
               bit_idx_nx = bit_idx;
            end
         end
         TX_PARITY: begin
            line_nx = frame[WORD_LENGTH];
            if (tick) begin
               state_nx = TX_STOP;
            end else begin
               state_nx = TX_PARITY;
            end
         end
         TX_STOP: begin
            line_nx = 1'b1;
            if (tick) begin
               state_nx = TX_ACK_WAIT;
            end else begin
               state_nx = TX_STOP;
            end
         end
         TX_ACK_WAIT: begin
            line_nx = IDLE_LEVEL;
            if (!tick) begin
               nack_nx = nack_now;
            end else if (!nack_now) begin
               done_nx  = 1'b1;
               state_nx = TX_IDLE;
            end else if (retry < RETRY_MAX) begin
               retry_nx = retry + RW'(1);
               state_nx = TX_START;
            end else begin
               fail_nx  = 1'b1;
               state_nx = TX_IDLE;
            end
         end
         default: begin
            state_nx = TX_IDLE;
            line_nx  = IDLE_LEVEL;
         end
      endcase
   end

   // State, frame data and registered outputs.
   always_ff @(posedge t_clk or negedge t_rst_n) begin
      if (!t_rst_n) begin
         state   <= TX_IDLE;
         frame   <= '0;
         bit_idx <= '0;
         retry   <= '0;
         nack    <= 1'b0;
         line    <= IDLE_LEVEL;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         fail    <= 1'b0;
      end else begin
         state   <= state_nx;
         frame   <= frame_nx;
         bit_idx <= bit_idx_nx;
         retry   <= retry_nx;
         nack    <= nack_nx;
         line    <= line_nx;
         ready   <= (state_nx == TX_IDLE);
         busy    <= (state_nx != TX_IDLE);
         done    <= done_nx;
         fail    <= fail_nx;
      end
   end

   assign UART_Tx_OUT = line;
   assign tx_ready    = ready;
   assign tx_busy     = busy;
   assign tx_done     = done;
   assign tx_fail     = fail;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with BIT_CYC = 16. Each word gets a per-frame plan for the
// acknowledge line; the expected frame count, line waveform and done/fail
// timing are worked out from the frame layout and the synchroniser delay.
module tb_uart_tx;

   localparam int BC  = 16;
   localparam int FL  = 12 * BC;   // start + 8 data + parity + stop + ack window
   localparam int MXR = 2;

   logic       t_clk;
   logic       t_rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       err_ack;
   logic       UART_Tx_OUT;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_fail;

   int n_cmp = 0;
   int n_bad = 0;
   int ps[MXR+1];
   int pl[MXR+1];

   uart_tx #(
      .CLKRATE     (16),
      .BAUD        (1),
      .WORD_LENGTH (8),
      .MAX_RETRY   (MXR)
   ) dut (
      .t_clk       (t_clk),
      .t_rst_n     (t_rst_n),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .err_ack     (err_ack),
      .UART_Tx_OUT (UART_Tx_OUT),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_fail     (tx_fail)
   );

   initial t_clk = 1'b0;
   always #5 t_clk = ~t_clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Plan for frame f: err_ack high from frame-local cycle s for l cycles (l = 0: none).
   task automatic set_plan(input int f, input int s, input int l);
      ps[f] = s;
      pl[f] = (l > FL - s) ? FL - s : l;
   endtask

   // A pulse driven from local cycle s is visible after synchronisation in
   // cycles s+2 .. s+l+1; it counts if that overlaps the ack window.
   function automatic bit counted(input int s, input int l);
      return (l > 0) && (s + 2 <= FL - 1) && (s + l + 1 >= FL - BC);
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge of the
   // first idle cycle after the word completes.
   task automatic send_word(input logic [7:0] d, input bit hold);
      logic [11:0] bits;
      int  nfr;
      int  tries;
      bit  fail_exp;
      int  f;
      int  loc;
      bits     = {1'b1, 1'b1, ^d, d, 1'b0};
      nfr      = 0;
      tries    = 0;
      fail_exp = 1'b0;
      for (int i = 0; i <= MXR; i++) begin
         nfr = i + 1;
         if (!counted(ps[i], pl[i])) break;
         if (tries < MXR) begin
            tries++;
         end else begin
            fail_exp = 1'b1;
            break;
         end
      end
      check_eq("ready_before_accept", 32'(tx_ready), 32'd1);
      tx_data  = d;
      tx_valid = 1'b1;
      err_ack  = 1'b0;
      for (int k = 0; k <= nfr * FL; k++) begin
         @(negedge t_clk);
         if (hold) begin
            tx_data = 8'($urandom);
         end else begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
         end
         f   = k / FL;
         loc = k % FL;
         err_ack = (f < nfr) && (pl[f] > 0) && (loc >= ps[f]) && (loc < ps[f] + pl[f]);
         if (k == 0) begin
            check_eq("line_accept_cycle", 32'(UART_Tx_OUT), 32'd1);
         end else begin
            check_eq("line", 32'(UART_Tx_OUT), 32'(bits[((k - 1) % FL) / BC]));
         end
         check_eq("busy",  32'(tx_busy),  32'(k < nfr * FL));
         check_eq("ready", 32'(tx_ready), 32'(k == nfr * FL));
         check_eq("done",  32'(tx_done),  32'((k == nfr * FL) && !fail_exp));
         check_eq("fail",  32'(tx_fail),  32'((k == nfr * FL) && fail_exp));
      end
      err_ack = 1'b0;
   endtask

   task automatic no_ack_plan();
      for (int i = 0; i <= MXR; i++) set_plan(i, 0, 0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge t_clk);
         check_eq("idle_line", 32'(UART_Tx_OUT), 32'd1);
         check_eq("idle_busy", 32'(tx_busy), 32'd0);
         check_eq("idle_done", 32'(tx_done), 32'd0);
         check_eq("idle_fail", 32'(tx_fail), 32'd0);
      end
   endtask

   initial begin
      t_rst_n  = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      err_ack  = 1'b0;
      #12;
      check_eq("rst_line",  32'(UART_Tx_OUT), 32'd1);
      check_eq("rst_ready", 32'(tx_ready), 32'd1);
      check_eq("rst_busy",  32'(tx_busy), 32'd0);
      check_eq("rst_done",  32'(tx_done), 32'd0);
      check_eq("rst_fail",  32'(tx_fail), 32'd0);
      @(negedge t_clk);
      t_rst_n = 1'b1;
      idle_cycles(3);

      // Basic frame and odd-popcount parity.
      no_ack_plan();
      send_word(8'hA5, 1'b0);
      idle_cycles(2);
      send_word(8'h07, 1'b0);
      idle_cycles(2);

      // Single retry: NOT_OK for 5 cycles inside the first window.
      no_ack_plan();
      set_plan(0, FL - BC + 2, 5);
      send_word(8'h3C, 1'b0);
      idle_cycles(2);

      // Retry exhaustion with NOT_OK held through every frame.
      for (int i = 0; i <= MXR; i++) set_plan(i, 0, FL);
      send_word(8'h5A, 1'b0);
      idle_cycles(2);

      // Window edges: pulse landing after the window is ignored, one landing
      // on the first window cycle counts.
      no_ack_plan();
      set_plan(0, FL - 2, 2);
      send_word(8'h81, 1'b0);
      no_ack_plan();
      set_plan(0, FL - BC - 2, 5);
      send_word(8'h42, 1'b0);
      idle_cycles(1);

      // Back-to-back with tx_valid held and tx_data churning mid-frame.
      no_ack_plan();
      send_word(8'hC3, 1'b1);
      send_word(8'h1E, 1'b0);
      idle_cycles(2);

      // Reset during data bit 4 of 8'hFF.
      no_ack_plan();
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      for (int k = 0; k <= 86; k++) begin
         @(negedge t_clk);
         tx_valid = 1'b0;
      end
      check_eq("pre_rst_busy", 32'(tx_busy), 32'd1);
      check_eq("pre_rst_line", 32'(UART_Tx_OUT), 32'd1);
      #2 t_rst_n = 1'b0;
      #1;
      check_eq("mid_rst_line",  32'(UART_Tx_OUT), 32'd1);
      check_eq("mid_rst_busy",  32'(tx_busy), 32'd0);
      check_eq("mid_rst_ready", 32'(tx_ready), 32'd1);
      idle_cycles(3);
      t_rst_n = 1'b1;
      idle_cycles(4);
      send_word(8'h00, 1'b0);
      idle_cycles(1);

      // Randomised words and acknowledge plans.
      for (int w = 0; w < 24; w++) begin
         bit hold;
         int mode;
         for (int i = 0; i <= MXR; i++) begin
            mode = $urandom_range(0, 3);
            if (mode == 0 || mode == 1) begin
               set_plan(i, 0, 0);
            end else if (mode == 2) begin
               set_plan(i, $urandom_range(FL - BC - 30, FL - 1), $urandom_range(3, 6));
            end else begin
               set_plan(i, 0, FL);
            end
         end
         hold = (w != 23) && ($urandom_range(0, 2) == 0);
         send_word(8'($urandom), hold);
         if (!hold) idle_cycles($urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
